// File: rtl/trig_pkg.sv
// trig_pkg: shared state encoding and edge_mode constants for the trigger controller
package trig_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLDOFF = 2'd1, ARMED = 2'd2, TRIGGERED = 2'd3} trig_state_t;
  localparam logic [1:0] EM_RISE = 2'b00;
  localparam logic [1:0] EM_FALL = 2'b01;
  localparam logic [1:0] EM_EITHER = 2'b10;
  localparam logic [1:0] EM_LEVEL = 2'b11;
endpackage

// File: rtl/trig_sync_edge.sv
// trig_sync_edge: 2-flop synchronizer plus history flop with edge/level detection
module trig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic level
);
  logic s1, s2, h;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, h} <= 3'b000;
    else {s1, s2, h} <= {din, s1, s2};
  assign rise = s2 & ~h;
  assign fall = ~s2 & h;
  assign level = s2;
endmodule

// File: rtl/trig_ctrl_n.sv
// trig_ctrl_n: selectable-channel trigger controller with holdoff, force and capture release
module trig_ctrl_n
  import trig_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int HOLD_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         trig_in,
  input  logic [$clog2(N_CH)-1:0] src_sel,
  input  logic [1:0]              edge_mode,
  input  logic [HOLD_W-1:0]       holdoff,
  input  logic                    arm,
  input  logic                    trig_en,
  input  logic                    force_trig,
  input  logic                    set_capture_done,
  output logic                    trigger,
  output logic                    trig_pulse,
  output logic [$clog2(N_CH)-1:0] trig_src,
  output logic [1:0]              state_o
);
  trig_state_t state, nxt;
  logic [HOLD_W-1:0] cnt, cnt_nxt;
  logic [N_CH-1:0] rise, fall, lvl;
  logic evt, hit;
  genvar i;
  // history lives per channel so switching src_sel cannot fake an edge
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      trig_sync_edge u_sync (.clk(clk), .rst_n(rst_n), .din(trig_in[i]), .rise(rise[i]), .fall(fall[i]), .level(lvl[i]));
    end
  endgenerate
  assign evt = edge_mode == EM_RISE   ? rise[src_sel] :
               edge_mode == EM_FALL   ? fall[src_sel] :
               edge_mode == EM_EITHER ? rise[src_sel] | fall[src_sel] : lvl[src_sel];
  assign hit = state == ARMED && (force_trig || (trig_en && evt));
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: if (arm) begin
        cnt_nxt = holdoff;
        nxt = holdoff == '0 ? ARMED : HOLDOFF;
      end
      HOLDOFF: begin
        cnt_nxt = cnt - HOLD_W'(1);
        if (cnt == HOLD_W'(1)) nxt = ARMED;
      end
      ARMED: if (hit) nxt = TRIGGERED;
      default: ;
    endcase
    if (set_capture_done) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      trigger <= 1'b0;
      trig_pulse <= 1'b0;
      trig_src <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      trigger <= nxt == TRIGGERED;
      trig_pulse <= nxt == TRIGGERED && state != TRIGGERED;
      if (nxt == TRIGGERED && state != TRIGGERED) trig_src <= src_sel;
    end
  assign state_o = state;
endmodule
